fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the Simple_CPU, placed between `program_counter` and the decoder. It reads the current `pc`, issues single-outstanding requests to instruction memory, and buffers returned words with their addresses in a small FIFO. It drives `next_pc` back into `program_counter` and presents instructions to decode through a valid/ready handshake. Branch/jump redirects from execute flush the buffer.

## Interface
- `DEPTH`, 2, instruction FIFO entries; power of two, ≥2.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc`  in  32  current PC from `program_counter`.
- `next_pc`  out  32  next PC value to `program_counter`; `program_counter` loads it every cycle.
- `redirect`  in  1  flush and jump request from execute.
- `redirect_pc`  in  32  target address, valid when `redirect`=1.
- `imem_req_valid`  out  1  memory request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  32  request address; equals `pc`.
- `imem_resp_valid`  in  1  response word valid; a one-cycle pulse.
- `imem_resp_data`  in  32  instruction word.
- `inst_valid`  out  1  FIFO head valid to decode.
- `inst_ready`  in  1  decode accepts the head.
- `inst`  out  32  head instruction.
- `inst_pc`  out  32  address of the head instruction.

## Operation
- The FSM has three states:
  - REQ: may issue a request.
  - WAIT: one request is outstanding.
  - DROP: the outstanding response will be discarded.
- Request gating: `imem_req_valid` = (state==REQ) && (count<DEPTH) && !`redirect`.
- A request handshake occurs when `imem_req_valid` and `imem_req_ready` are both 1.
  - The FSM goes REQ→WAIT.
  - `pc` is latched into the request-address register `req_pc`.
- WAIT, on `imem_resp_valid`:
  - Push {`req_pc`, `imem_resp_data`} into the FIFO.
  - Go to REQ.
- `next_pc` selection, in priority order:
  1. `redirect`=1 → `redirect_pc`.
  2. Request handshake → `pc`+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  3. Otherwise → `pc`, which holds the PC.
- Redirect handling:
  - The FIFO is cleared at the clock edge, so `inst_valid`=0 in the next cycle. A pop in that cycle is ignored.
  - From REQ: stay in REQ.
  - From WAIT with no response in the same cycle: go to DROP.
  - From WAIT with a response in the same cycle: discard the response and go to REQ.
  - From DROP: stay in DROP.
- DROP: the next `imem_resp_valid` is discarded and the FSM goes to REQ. Only one outstanding request exists, so exactly one response is dropped.
- FIFO:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - A push when count==DEPTH cannot occur because of the request gating; it is an assertion error.
  - `inst` and `inst_pc` are don't-care while `inst_valid`=0.
- Alignment: `pc`[1:0] is passed through unchanged; there is no checking.

## Timing
- Reset state, asynchronous and immediate:
  - FSM = REQ, FIFO empty, `req_pc`=0.
  - `inst_valid`=0, `imem_req_valid`=0, `next_pc`=`pc`.
  - `inst`=0, `inst_pc`=0.
- The first request is issued in the first cycle after `rst` deasserts, with `imem_addr`=`pc`.
- Response latency is ≥1 cycle after the request handshake. A response arriving in the handshake cycle is illegal.
- Without bypass: `inst_valid` rises in the cycle after `imem_resp_valid`.
- With single-cycle memory: the handshake is in cycle N, the response in N+1, `inst_valid` in N+2. Steady throughput is 1 instruction per 2 cycles.
- `imem_req_valid` stays asserted until ready while gating holds. `imem_addr` is stable, because `next_pc`=`pc` until the handshake.
- `redirect` is sampled each cycle. Its effect on `next_pc` and `imem_req_valid` is combinational in the same cycle.

## Configuration
- `FETCH_BYPASS_EN` defined: bypass conditions are FIFO empty, state==WAIT, `imem_resp_valid`=1 and `redirect`=0.
  - Under those conditions, `inst_valid`=1 in the same cycle, with `inst`/`inst_pc` taken from `imem_resp_data`/`req_pc`.
  - If `inst_ready`=1 as well, the word is consumed and not pushed. Otherwise it is pushed as normal.
- `FETCH_BYPASS_EN` undefined: every word passes through the FIFO, adding one cycle. All outputs are registered except `next_pc` and `imem_req_valid`.

## Test plan
- Reset and fetch:
  - Stimulus: `rst`=0 with `pc`=0, then release; memory always ready; 1-cycle response with data 32'hA0, then 32'hA4.
  - Required: the first request has `imem_addr`=0, `next_pc`=4 in the handshake cycle, and decode receives (`inst_pc` 0, `inst` A0), then (4, A4).
- Backpressure:
  - Stimulus: `inst_ready`=0.
  - Required: after DEPTH words are buffered, `imem_req_valid`=0 and `next_pc`=`pc` hold. Raising `inst_ready` drains the words in order and fetching resumes.
- Redirect in WAIT:
  - Stimulus: `redirect`=1, `redirect_pc`=32'h100 while a response is outstanding.
  - Required: `next_pc`=32'h100, the FIFO is empty next cycle, the late response is dropped, and the next request has `imem_addr`=32'h100.
- Redirect coincident with response:
  - Stimulus: `redirect` and `imem_resp_valid` in the same cycle.
  - Required: the word is not delivered and the FSM returns to REQ next cycle.
- Wrap:
  - Stimulus: handshake with `pc`=32'hFFFF_FFFC.
  - Required: `next_pc`=0.
- Async reset mid-WAIT:
  - Stimulus: `rst` drops mid-cycle.
  - Required: `inst_valid` and `imem_req_valid` are 0 immediately, and a stale response after release is not delivered.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and decode-side handshake bundle for fetch_unit.
// master = fetch stage, slave = memory/decoder environment.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requests, DEPTH-entry {pc, word} FIFO to decode.
// Optional same-cycle bypass of the FIFO when FETCH_BYPASS_EN is defined.
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      mem_pc_q   [DEPTH];
    logic [31:0]      mem_pc_d   [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [31:0]      mem_data_d [DEPTH];

    logic fifo_empty;
    logic fifo_has_room;
    logic req_valid;
    logic handshake;
    logic resp_take;
    logic bypass;
    logic push;
    logic pop;

    assign fifo_empty    = (count_q == '0);
    assign fifo_has_room = (count_q < CNT_W'(DEPTH));

    // rst gates the combinational outputs so they are quiet for the whole reset window
    assign req_valid = rst && (state_q == S_REQ) && fifo_has_room && !redirect;
    assign handshake = req_valid && bus.imem_req_ready;
    assign resp_take = (state_q == S_WAIT) && bus.imem_resp_valid && !redirect;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc;

    always_comb begin
        next_pc = pc;
        if (rst && redirect) begin
            next_pc = redirect_pc;
        end else if (handshake) begin
            next_pc = pc + 32'd4;
        end
    end

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_take && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign bus.inst_valid = !fifo_empty || bypass;
    assign bus.inst       = bypass ? bus.imem_resp_data : mem_data_q[rd_ptr_q];
    assign bus.inst_pc    = bypass ? req_pc_q : mem_pc_q[rd_ptr_q];

    assign push = resp_take && !(bypass && bus.inst_ready);
    assign pop  = !fifo_empty && bus.inst_ready && !redirect;

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        case (state_q)
            S_REQ: begin
                if (handshake) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // a response coinciding with redirect is discarded by resp_take
                if (bus.imem_resp_valid) begin
                    state_d = S_REQ;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (handshake) begin
            req_pc_d = pc;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_pc_d   = mem_pc_q;
        mem_data_d = mem_data_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_pc_d[wr_ptr_q]   = req_pc_q;
                mem_data_d[wr_ptr_q] = bus.imem_resp_data;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            req_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_pc_q   <= '{default: '0};
            mem_data_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_pc_q   <= mem_pc_d;
            mem_data_q <= mem_data_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !fifo_has_room));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: responder models imem, scoreboard queue checks decode output.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_unit_if bus();

    fetch_unit #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // program_counter stand-in: loads next_pc every cycle
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= 32'h0;
        else      pc <= next_pc;
    end

    logic [63:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;
    int mem_lat   = 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one();
        int n;
        n = 0;
        cyc();
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        while (!bus.imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_handshake", {31'd0, bus.imem_req_valid}, 32'd1);
        @(posedge clk);
        #1;
        bus.imem_req_ready = 1'b0;
    endtask

    task automatic wait_q_le(input int lvl, input int lim);
        int n;
        n = 0;
        while (exp_q.size() > lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'(lvl));
    endtask

    // imem model: data word is address + 0xA0, returned mem_lat cycles after the handshake
    initial begin : responder
        logic [31:0] a;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst && bus.imem_req_valid && bus.imem_req_ready) begin
                a = bus.imem_addr;
                repeat (mem_lat) @(posedge clk);
                #1;
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = a + 32'hA0;
                @(posedge clk);
                #1;
                bus.imem_resp_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst && bus.inst_valid && bus.inst_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_inst: got pc %h inst %h, none expected",
                             bus.inst_pc, bus.inst);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.inst_pc, bus.inst} === e) pass_cnt++;
                    else $display("FAIL inst: got pc %h inst %h expected pc %h inst %h",
                                  bus.inst_pc, bus.inst, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        redirect           = 1'b0;
        redirect_pc        = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_req_valid",  {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst_next_pc",    next_pc, 32'h0);
        chk("rst_inst",       bus.inst, 32'h0);
        chk("rst_inst_pc",    bus.inst_pc, 32'h0);
        repeat (2) cyc();

        // reset release and basic fetch
        rst = 1'b1;
        bus.imem_req_ready = 1'b1;
        exp_q.push_back({32'h0, 32'hA0});
        exp_q.push_back({32'h4, 32'hA4});
        @(negedge clk);
        chk("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("first_addr",      bus.imem_addr, 32'h0);
        chk("first_next_pc",   next_pc, 32'h4);
        cyc();
        @(negedge clk);
        chk("resp_cycle_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        cyc();
        @(negedge clk);
        chk("second_addr",    bus.imem_addr, 32'h4);
        chk("second_next_pc", next_pc, 32'h8);
        cyc();
        bus.imem_req_ready = 1'b0;
        cyc();
        @(negedge clk);
        chk("hold_next_pc",   next_pc, 32'h8);
        chk("hold_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        wait_q_le(0, 20);

        // backpressure: fill both entries, then drain and resume
        cyc();
        bus.inst_ready     = 1'b0;
        bus.imem_req_ready = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        chk("full_req_valid",  {31'd0, bus.imem_req_valid}, 32'd0);
        chk("full_next_pc",    next_pc, 32'h10);
        chk("full_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
        cyc();
        @(negedge clk);
        chk("full_req_valid2", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("full_next_pc2",   next_pc, 32'h10);
        cyc();
        exp_q.push_back({32'h8,  32'hA8});
        exp_q.push_back({32'hC,  32'hAC});
        exp_q.push_back({32'h10, 32'hB0});
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b1;
        wait_q_le(1, 20);
        fetch_one();
        wait_q_le(0, 20);

        // redirect while a response is outstanding; buffered word is flushed too
        cyc();
        bus.inst_ready = 1'b0;
        mem_lat = 1;
        fetch_one();
        mem_lat = 3;
        fetch_one();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        chk("redir_next_pc",    next_pc, 32'h100);
        chk("redir_req_valid",  {31'd0, bus.imem_req_valid}, 32'd0);
        chk("redir_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk("flushed_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("drop_req_valid",     {31'd0, bus.imem_req_valid}, 32'd0);
        cyc();
        @(negedge clk);
        chk("drop_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        cyc();
        @(negedge clk);
        chk("after_drop_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("after_drop_addr",      bus.imem_addr, 32'h100);
        cyc();
        bus.inst_ready = 1'b1;
        mem_lat = 1;
        exp_q.push_back({32'h100, 32'h1A0});
        fetch_one();
        wait_q_le(0, 20);

        // redirect in the same cycle as the response
        mem_lat = 2;
        fetch_one();
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        chk("coinc_next_pc",   next_pc, 32'h200);
        chk("coinc_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk("coinc_back_req",   {31'd0, bus.imem_req_valid}, 32'd1);
        chk("coinc_addr",       bus.imem_addr, 32'h200);
        chk("coinc_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        cyc();
        @(negedge clk);
        chk("coinc_inst_valid2", {31'd0, bus.inst_valid}, 32'd0);

        // wrap of the incremented PC
        cyc();
        mem_lat     = 1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        bus.imem_req_ready = 1'b1;
        exp_q.push_back({32'hFFFF_FFFC, 32'h0000_009C});
        @(negedge clk);
        chk("wrap_addr",    bus.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_next_pc", next_pc, 32'h0);
        cyc();
        bus.imem_req_ready = 1'b0;
        wait_q_le(0, 20);

        // asynchronous reset while waiting, stale response after release
        cyc();
        bus.inst_ready = 1'b0;
        mem_lat = 1;
        fetch_one();
        mem_lat = 3;
        fetch_one();
        #2;
        chk("pre_reset_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("async_req_valid",  {31'd0, bus.imem_req_valid}, 32'd0);
        chk("async_inst_pc",    bus.inst_pc, 32'h0);
        chk("async_next_pc",    next_pc, 32'h0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("release_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        cyc();
        @(negedge clk);
        chk("stale_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("stale_req_valid",  {31'd0, bus.imem_req_valid}, 32'd1);
        cyc();
        @(negedge clk);
        chk("stale_inst_valid2", {31'd0, bus.inst_valid}, 32'd0);
        cyc();
        bus.inst_ready = 1'b1;
        mem_lat = 1;
        exp_q.push_back({32'h0, 32'hA0});
        fetch_one();
        wait_q_le(0, 20);

        repeat (3) cyc();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
